header_walk_tester: RTL



---
 rtl/header_test_pkg.sv | 24 ++
 rtl/header_walk_tester_dwell_timer.sv | 55 +++++
 rtl/header_walk_tester.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/header_test_pkg.sv
// ---------------------------------------------------------------------------
// header_test_pkg
// Shared types and constants for the breakout-header walk tester.
//   state_e          : sweep controller states
//   NUM_PINS_DEFAULT : pins on the external breakout header
//   IDX_W            : width of every pin index and pin count
//   NO_FAIL          : first_fail_idx value meaning "no failing pin yet"
// ---------------------------------------------------------------------------
package header_test_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        HOLD,
        DONE
    } state_e;

    localparam int NUM_PINS_DEFAULT = 37;
    localparam int IDX_W            = 6;

    localparam logic [IDX_W-1:0] NO_FAIL = 6'h3F;

endpackage

// File: rtl/header_walk_tester_dwell_timer.sv
// ---------------------------------------------------------------------------
// dwell_timer
// Counts the clock cycles spent on the pin currently under test and flags
// the end of the settle window and the end of the dwell.
//   clk        : system clock
//   rst_n      : synchronous active-low reset
//   clear      : forces the count to zero on the next edge
//   count      : cycles elapsed since the last clear
//   settle_hit : count is on the last settle cycle
//   dwell_hit  : count is on the last cycle of the dwell
// ---------------------------------------------------------------------------
module dwell_timer
    import header_test_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int TICK_DIV      = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    output logic [31:0] count,
    output logic        settle_hit,
    output logic        dwell_hit
);

    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] DWELL_LAST  = 32'(TICK_DIV - 1);

    logic [31:0] count_q;
    logic [31:0] count_d;

    // The counter free-runs unless the controller clears it; the controller
    // holds clear high whenever no step is in progress, so the count is
    // already zero on the first cycle of every step.
    always_comb begin
        count_d = count_q + 32'd1;
        if (clear) begin
            count_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign settle_hit = (count_q == SETTLE_LAST);
    assign dwell_hit  = (count_q == DWELL_LAST);

endmodule

// File: rtl/header_walk_tester.sv
// ---------------------------------------------------------------------------
// header_walk_tester
// Walks a single one (or single zero) across the breakout header pins,
// dwelling TICK_DIV cycles per pin, and checks the loopback copy of the
// header once per pin after a settle window. Per-pin failures are counted
// and the first failing pin is remembered.
//   clk            : system clock
//   rst_n          : synchronous active-low reset
//   start          : single-cycle sweep request (ignored while busy)
//   mode           : 0 = walking-one, 1 = walking-zero, latched on start
//   bus_in         : synchronised loopback sample of the header pins
//   bus_out        : registered pattern driven to the header
//   pin_idx        : pin currently under test
//   busy           : sweep in progress
//   done           : sweep finished, results valid
//   pass           : no pin failed (meaningful while done)
//   fail_count     : pins with at least one mismatching bit
//   first_fail_idx : first failing pin, NO_FAIL if none
// SETTLE_CYCLES must lie in 1 .. TICK_DIV-1.
// ---------------------------------------------------------------------------
module header_walk_tester
    import header_test_pkg::*;
#(
    parameter int NUM_PINS      = NUM_PINS_DEFAULT,
    parameter int TICK_DIV      = 50000,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                mode,
    input  logic [NUM_PINS-1:0] bus_in,
    output logic [NUM_PINS-1:0] bus_out,
    output logic [IDX_W-1:0]    pin_idx,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [IDX_W-1:0]    fail_count,
    output logic [IDX_W-1:0]    first_fail_idx
);

    localparam logic [IDX_W-1:0] LAST_PIN = IDX_W'(NUM_PINS - 1);

    state_e              state_q,      state_d;
    logic                mode_q,       mode_d;
    logic [NUM_PINS-1:0] bus_out_q,    bus_out_d;
    logic [IDX_W-1:0]    pin_idx_q,    pin_idx_d;
    logic                busy_q,       busy_d;
    logic                done_q,       done_d;
    logic                pass_q,       pass_d;
    logic [IDX_W-1:0]    fail_count_q, fail_count_d;
    logic [IDX_W-1:0]    first_fail_q, first_fail_d;

    logic        timer_clear;
    logic        step_end;
    logic [31:0] timer_count;
    logic        settle_hit;
    logic        dwell_hit;

    // Pattern for pin idx: a lone one (walk_zero = 0) or a lone zero.
    function automatic logic [NUM_PINS-1:0] pattern(input logic walk_zero,
                                                    input logic [IDX_W-1:0] idx);
        logic [NUM_PINS-1:0] one_hot;
        one_hot = {{(NUM_PINS-1){1'b0}}, 1'b1} << idx;
        return walk_zero ? ~one_hot : one_hot;
    endfunction

    dwell_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .TICK_DIV      (TICK_DIV)
    ) u_dwell_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (timer_clear),
        .count      (timer_count),
        .settle_hit (settle_hit),
        .dwell_hit  (dwell_hit)
    );

    // Sweep controller. Every step is SETTLE (count 0 .. SETTLE_CYCLES-1),
    // one SAMPLE cycle, then HOLD until the dwell ends. SAMPLE also honours
    // the end of the dwell so a settle window of TICK_DIV-1 still works.
    // The step-end handling runs after the case so that pass sees a failure
    // recorded by a SAMPLE that is also the last cycle of the sweep.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        bus_out_d    = bus_out_q;
        pin_idx_d    = pin_idx_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        fail_count_d = fail_count_q;
        first_fail_d = first_fail_q;
        timer_clear  = 1'b0;
        step_end     = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                timer_clear = 1'b1;
                bus_out_d   = '0;
                if (start) begin
                    mode_d       = mode;
                    fail_count_d = '0;
                    first_fail_d = NO_FAIL;
                    pin_idx_d    = '0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    bus_out_d    = pattern(mode, '0);
                    state_d      = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_hit) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (|(bus_in ^ bus_out_q)) begin
                    fail_count_d = fail_count_q + IDX_W'(1);
                    if (first_fail_q == NO_FAIL) begin
                        first_fail_d = pin_idx_q;
                    end
                end
                state_d  = HOLD;
                step_end = dwell_hit;
            end
            HOLD: begin
                step_end = dwell_hit;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (step_end) begin
            timer_clear = 1'b1;
            if (pin_idx_q < LAST_PIN) begin
                pin_idx_d = pin_idx_q + IDX_W'(1);
                bus_out_d = pattern(mode_q, pin_idx_q + IDX_W'(1));
                state_d   = SETTLE;
            end else begin
                bus_out_d = '0;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                pass_d    = (fail_count_d == '0);
                state_d   = DONE;
            end
        end
    end

    // State and result registers. Reset releases the header to all zeros
    // and leaves the block idle until the next start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mode_q       <= 1'b0;
            bus_out_q    <= '0;
            pin_idx_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_count_q <= '0;
            first_fail_q <= NO_FAIL;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            bus_out_q    <= bus_out_d;
            pin_idx_q    <= pin_idx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_count_q <= fail_count_d;
            first_fail_q <= first_fail_d;
        end
    end

    // The settle window must never run past its last cycle; if it did, the
    // sample point would drift away from the pattern change.
    always_ff @(posedge clk) begin
        if (rst_n && state_q == SETTLE) begin
            assert (timer_count < 32'(SETTLE_CYCLES));
        end
    end

    assign bus_out        = bus_out_q;
    assign pin_idx        = pin_idx_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign fail_count     = fail_count_q;
    assign first_fail_idx = first_fail_q;

endmodule
